adder_cla_pipe: RTL and testbench
=================================

ADDER_CLA_PIPE -- requirements
Module: adder_cla_pipe

Interface
REQ-001 SHALL have parameter N, default 32: operand/sum width in bits.
REQ-002 SHALL have parameter B, default 8: lookahead block width; N % B == 0 and 1 <= B <= N, otherwise elaboration error.
REQ-003 SHALL port clk  input  1  single clock, rising edge.
REQ-004 SHALL port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL port i_valid  input  1  operand beat present.
REQ-006 SHALL port i_ready  output  1  block accepts beat this cycle.
REQ-007 SHALL port i_a, i_b  input  N each  operands.
REQ-008 SHALL port i_ci  input  1  carry-in.
REQ-009 SHALL port i_sub  input  1  1 = subtract (a - b), 0 = add.
REQ-010 SHALL port o_valid  output  1  result beat present.
REQ-011 SHALL port o_ready  input  1  downstream accepts result.
REQ-012 SHALL port o_s  output  N  sum/difference.
REQ-013 SHALL port o_co  output  1  carry-out of bit N-1.
REQ-014 SHALL port o_ovf  output  1  signed overflow (present only per REQ-029).

Function
REQ-015 SHALL split operands into S = N/B blocks; stage k (k = 0..S-1) computes block k with a B-bit carry-lookahead (propagate/generate) sum and registers its carry into stage k+1.
REQ-016 SHALL apply operand transform at acceptance: b' = i_sub ? ~i_b : i_b, c0 = i_ci ^ i_sub.
REQ-017 SHALL skew operands: block k of a/b' enters stage k exactly k cycles after acceptance; completed sum blocks travel alongside the beat (de-skew) so o_s is presented whole.
REQ-018 SHALL have latency exactly S cycles from accepting edge to o_valid high, when o_ready held high.
REQ-019 SHALL sustain throughput one beat per cycle while o_ready = 1.
REQ-020 SHALL advance the whole pipeline on en = ~o_valid | o_ready; i_ready = en (combinational); beat accepted when i_valid & i_ready.
REQ-021 SHALL hold all stages, including o_s/o_co/o_valid, stable while en = 0; no beat lost or duplicated.
REQ-022 SHALL propagate bubbles as invalid stages (no compaction); a stage's valid bit follows the beat.
REQ-023 SHALL give o_co = carry out of bit N-1 of a + b' + c0 (raw carry; for subtract, 1 = no borrow).
REQ-024 SHALL, with S = 1 (B = N), degenerate to a single registered stage, latency 1.

Reset
REQ-025 SHALL on rst_n low asynchronously clear all stage valid bits, o_valid = 0, o_s = 0, o_co = 0, o_ovf = 0.
REQ-026 SHALL discard in-flight beats on reset mid-operation; after rst_n rises, first output appears only from a beat accepted after release.
REQ-027 SHALL drive i_ready = 1 during and after reset (pipeline empty).

Configuration
REQ-028 SHALL honour macro ADDER_CLA_PIPE_OVF_EN.
REQ-029 With ADDER_CLA_PIPE_OVF_EN defined: o_ovf = (a[N-1] == b'[N-1]) & (o_s[N-1] != a[N-1]), aligned with o_s; without it: port o_ovf absent, no related logic.

Structure
REQ-030 SHALL place in shared package adder_pkg: stage-count function (N/B), parameter-check constants, and a beat struct/typedef {valid, sum, carry, ovf}.
REQ-031 SHALL use one combinational sub-module adder_cla_blk (B-bit, inputs a, b, ci; outputs s, co, p_all, g_all) instantiated S times.

Verification (N=32, B=8, S=4)
REQ-032 add: a=0xFFFF_FFFF, b=0x1, ci=0, sub=0 -> 4 cycles later o_s=0x0000_0000, o_co=1, o_ovf=0.
REQ-033 sub: a=0x5, b=0x7, sub=1, ci=0 -> o_s=0xFFFF_FFFE, o_co=0; a=0x8000_0000, b=0x1, sub=1 -> o_ovf=1.
REQ-034 streaming: 100 random back-to-back beats, o_ready=1 -> 100 results in order, one per cycle, match golden model.
REQ-035 backpressure: o_ready toggled randomly 50% -> i_ready mirrors en, o_s stable while o_valid & ~o_ready, no loss/duplication.
REQ-036 reset mid-flight: 3 beats accepted, rst_n low 1 cycle -> o_valid=0 immediately, none of the 3 beats emerges.
REQ-037 degenerate: B=32, a=0x7FFF_FFFF, b=0x1 -> 1 cycle later o_s=0x8000_0000, o_co=0, o_ovf=1.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder: stage count, parameter checks,
// and the per-stage beat record.
package adder_pkg;

  // Widest operand a beat record can carry; N above this is rejected.
  localparam int unsigned MaxW = 256;

  function automatic int unsigned stage_count(input int unsigned n, input int unsigned b);
    return (b == 0) ? 1 : n / b;
  endfunction

  function automatic bit params_ok(input int unsigned n, input int unsigned b);
    return (b >= 1) && (b <= n) && (n % b == 0) && (n <= MaxW);
  endfunction

  // Sum blocks fill in from the bottom as the beat walks down the pipeline.
  typedef struct packed {
    logic            valid;
    logic [MaxW-1:0] sum;
    logic            carry;
    logic            ovf;
  } beat_t;

endpackage

// File: rtl/adder_cla_pipe_if.sv
// Operand/result handshake bundle for adder_cla_pipe.
// o_ovf exists only when ADDER_CLA_PIPE_OVF_EN is defined.
interface adder_cla_pipe_if #(
  parameter int unsigned N = 32
);
  logic         i_valid;
  logic         i_ready;
  logic [N-1:0] i_a;
  logic [N-1:0] i_b;
  logic         i_ci;
  logic         i_sub;
  logic         o_valid;
  logic         o_ready;
  logic [N-1:0] o_s;
  logic         o_co;
`ifdef ADDER_CLA_PIPE_OVF_EN
  logic         o_ovf;
`endif

  modport master (
    output i_valid, i_a, i_b, i_ci, i_sub, o_ready,
    input  i_ready, o_valid, o_s, o_co
`ifdef ADDER_CLA_PIPE_OVF_EN
    , input o_ovf
`endif
  );

  modport slave (
    input  i_valid, i_a, i_b, i_ci, i_sub, o_ready,
    output i_ready, o_valid, o_s, o_co
`ifdef ADDER_CLA_PIPE_OVF_EN
    , output o_ovf
`endif
  );

endinterface

// File: rtl/adder_cla_blk.sv
// Combinational B-bit carry-lookahead block with group propagate/generate outputs.
module adder_cla_blk #(
  parameter int unsigned B = 8
) (
  input  logic [B-1:0] a,
  input  logic [B-1:0] b,
  input  logic         ci,
  output logic [B-1:0] s,
  output logic         co,
  output logic         p_all,
  output logic         g_all
);
  logic [B-1:0] p;
  logic [B-1:0] g;
  logic [B:0]   c;
  logic         gen_pre;
  logic         prop_pre;

  assign p = a ^ b;
  assign g = a & b;

  // Each carry is the prefix generate over lower bits plus prefix propagate of ci.
  always_comb begin
    gen_pre  = 1'b0;
    prop_pre = 1'b1;
    c        = '0;
    c[0]     = ci;
    for (int i = 0; i < B; i++) begin
      gen_pre  = g[i] | (p[i] & gen_pre);
      prop_pre = prop_pre & p[i];
      c[i+1]   = gen_pre | (prop_pre & ci);
    end
  end

  assign s     = p ^ c[B-1:0];
  assign co    = c[B];
  assign p_all = prop_pre;
  assign g_all = gen_pre;

endmodule

// File: rtl/adder_cla_pipe.sv
// Pipelined adder/subtractor: one B-bit lookahead block per stage, carry registered between
// stages, operands skewed and sums de-skewed. Signed overflow under ADDER_CLA_PIPE_OVF_EN.
module adder_cla_pipe
  import adder_pkg::*;
#(
  parameter int unsigned N = 32,
  parameter int unsigned B = 8
) (
  input logic             clk,
  input logic             rst_n,
  adder_cla_pipe_if.slave bus
);
  localparam int unsigned S = stage_count(N, B);

  if (!params_ok(N, B)) begin : g_param_err
    $error("adder_cla_pipe: N must be a multiple of B with 1 <= B <= N");
  end

  logic         en;
  logic [N-1:0] b_xf;
  logic         c0;
  logic [N-1:0] a_q [S];
  logic [N-1:0] b_q [S];
  beat_t        beat_q [S];
  logic [S-1:0] unused_p;
  logic [S-1:0] unused_g;

  assign en          = ~beat_q[S-1].valid | bus.o_ready;
  assign bus.i_ready = en;
  assign b_xf        = bus.i_sub ? ~bus.i_b : bus.i_b;
  assign c0          = bus.i_ci ^ bus.i_sub;

  for (genvar k = 0; k < S; k++) begin : g_stage
    logic [N-1:0] a_in;
    logic [N-1:0] b_in;
    beat_t        beat_in;
    beat_t        beat_d;
    logic [B-1:0] s_blk;
    logic         co_blk;

    if (k == 0) begin : g_src
      assign a_in = bus.i_a;
      assign b_in = b_xf;
      always_comb begin
        beat_in       = '0;
        beat_in.valid = bus.i_valid;
        beat_in.carry = c0;
      end
    end else begin : g_src
      assign a_in    = a_q[k-1];
      assign b_in    = b_q[k-1];
      assign beat_in = beat_q[k-1];
    end

    adder_cla_blk #(
      .B(B)
    ) u_blk (
      .a    (a_in[k*B +: B]),
      .b    (b_in[k*B +: B]),
      .ci   (beat_in.carry),
      .s    (s_blk),
      .co   (co_blk),
      .p_all(unused_p[k]),
      .g_all(unused_g[k])
    );

    always_comb begin
      beat_d               = beat_in;
      beat_d.sum[k*B +: B] = s_blk;
      beat_d.carry         = co_blk;
`ifdef ADDER_CLA_PIPE_OVF_EN
      if (k == S - 1) begin
        beat_d.ovf = (a_in[N-1] == b_in[N-1]) & (s_blk[B-1] != a_in[N-1]);
      end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        beat_q[k] <= '0;
        a_q[k]    <= '0;
        b_q[k]    <= '0;
      end else if (en) begin
        beat_q[k] <= beat_d;
        a_q[k]    <= a_in;
        b_q[k]    <= b_in;
      end
    end
  end

  assign bus.o_valid = beat_q[S-1].valid;
  assign bus.o_s     = beat_q[S-1].sum[N-1:0];
  assign bus.o_co    = beat_q[S-1].carry;

  // Last stage's operand copies and the record's spare sum bits feed nothing.
  logic unused_tail;
`ifdef ADDER_CLA_PIPE_OVF_EN
  assign bus.o_ovf   = beat_q[S-1].ovf;
  assign unused_tail = ^{a_q[S-1], b_q[S-1], beat_q[S-1].sum >> N, unused_p, unused_g};
`else
  assign unused_tail = ^{a_q[S-1], b_q[S-1], beat_q[S-1].sum >> N, beat_q[S-1].ovf,
                         unused_p, unused_g};
`endif

endmodule

// File: tb/tb_adder_cla_pipe.sv
// Directed self-checking bench for adder_cla_pipe (B=8 main instance, B=32 degenerate instance).
module tb_adder_cla_pipe;
  localparam int unsigned N = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  adder_cla_pipe_if #(.N(N)) bus ();
  adder_cla_pipe_if #(.N(N)) bus_deg ();

  adder_cla_pipe #(.N(N), .B(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  adder_cla_pipe #(.N(N), .B(32)) dut_deg (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_deg)
  );

  // Returns {ovf, co, s}.
  function automatic logic [N+1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic ci, input logic sub);
    logic [N-1:0] bx;
    logic [N:0]   r;
    bx = sub ? ~b : b;
    r  = {1'b0, a} + {1'b0, bx} + (N+1)'(ci ^ sub);
    return {(a[N-1] == bx[N-1]) && (r[N-1] != a[N-1]), r};
  endfunction

  function automatic logic [N-1:0] vec_a(input int i);
    return N'(32'h9E37_79B9 * (i + 1));
  endfunction

  function automatic logic [N-1:0] vec_b(input int i);
    return N'(32'hC2B2_AE35 * (i + 3)) ^ {i[0], 31'h0};
  endfunction

  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic ci,
                      input logic sub);
    bus.i_valid = 1'b1;
    bus.i_a     = a;
    bus.i_b     = b;
    bus.i_ci    = ci;
    bus.i_sub   = sub;
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.o_ready    = 1'b0;
    bus_deg.o_ready = 1'b1;
    #1;
    n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_o_valid: got %b want 0", bus.o_valid); end
    n_checks++; if (bus.o_s !== '0) begin n_fail++; $display("FAIL reset_o_s: got %h want 0", bus.o_s); end
    n_checks++; if (bus.o_co !== 1'b0) begin n_fail++; $display("FAIL reset_o_co: got %b want 0", bus.o_co); end
    n_checks++; if (bus.i_ready !== 1'b1) begin n_fail++; $display("FAIL reset_i_ready: got %b want 1", bus.i_ready); end
    n_checks++; if (bus_deg.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_deg_o_valid: got %b want 0", bus_deg.o_valid); end
`ifdef ADDER_CLA_PIPE_OVF_EN
    n_checks++; if (bus.o_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_o_ovf: got %b want 0", bus.o_ovf); end
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n       = 1'b1;
    bus.o_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.i_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_i_ready: got %b want 1", bus.i_ready); end
  endtask

  task automatic test_add();
    @(negedge clk);
    send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    @(negedge clk);
    bus.i_valid = 1'b0;
    for (int c = 1; c < 4; c++) begin
      n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL add_early_valid: cycle %0d got %b want 0", c, bus.o_valid); end
      @(negedge clk);
    end
    n_checks++; if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid: got %b want 1", bus.o_valid); end
    n_checks++; if (bus.o_s !== 32'h0) begin n_fail++; $display("FAIL add_s: got %h want 00000000", bus.o_s); end
    n_checks++; if (bus.o_co !== 1'b1) begin n_fail++; $display("FAIL add_co: got %b want 1", bus.o_co); end
`ifdef ADDER_CLA_PIPE_OVF_EN
    n_checks++; if (bus.o_ovf !== 1'b0) begin n_fail++; $display("FAIL add_ovf: got %b want 0", bus.o_ovf); end
`endif
    @(negedge clk);
    n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL add_no_dup: got %b want 0", bus.o_valid); end
  endtask

  task automatic test_sub();
    @(negedge clk);
    send(32'h5, 32'h7, 1'b0, 1'b1);
    @(negedge clk);
    send(32'h8000_0000, 32'h1, 1'b0, 1'b1);
    @(negedge clk);
    bus.i_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL sub1_valid: got %b want 1", bus.o_valid); end
    n_checks++; if (bus.o_s !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL sub1_s: got %h want fffffffe", bus.o_s); end
    n_checks++; if (bus.o_co !== 1'b0) begin n_fail++; $display("FAIL sub1_co: got %b want 0", bus.o_co); end
    @(negedge clk);
    n_checks++; if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL sub2_valid: got %b want 1", bus.o_valid); end
    n_checks++; if (bus.o_s !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL sub2_s: got %h want 7fffffff", bus.o_s); end
    n_checks++; if (bus.o_co !== 1'b1) begin n_fail++; $display("FAIL sub2_co: got %b want 1", bus.o_co); end
`ifdef ADDER_CLA_PIPE_OVF_EN
    n_checks++; if (bus.o_ovf !== 1'b1) begin n_fail++; $display("FAIL sub2_ovf: got %b want 1", bus.o_ovf); end
`endif
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [N+1:0] exp_q[$];
    logic [N+1:0] e;
    int got = 0;
    int first = -1;
    int last = -1;
    for (int c = 0; c < 108; c++) begin
      @(negedge clk);
      if (bus.o_valid === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL stream_extra: cycle %0d got s=%h want no beat", c, bus.o_s);
        end else begin
          e = exp_q.pop_front();
          if ({bus.o_co, bus.o_s} !== e[N:0]) begin n_fail++; $display("FAIL stream_sum: beat %0d got %h want %h", got, {bus.o_co, bus.o_s}, e[N:0]); end
`ifdef ADDER_CLA_PIPE_OVF_EN
          n_checks++; if (bus.o_ovf !== e[N+1]) begin n_fail++; $display("FAIL stream_ovf: beat %0d got %b want %b", got, bus.o_ovf, e[N+1]); end
`endif
        end
        got++;
        if (first < 0) first = c;
        last = c;
      end
      if (c < 100) begin
        send(vec_a(c), vec_b(c), c[2], c[1]);
        exp_q.push_back(model(vec_a(c), vec_b(c), c[2], c[1]));
      end else begin
        bus.i_valid = 1'b0;
      end
    end
    n_checks++; if (got != 100) begin n_fail++; $display("FAIL stream_count: got %0d want 100", got); end
    n_checks++; if (first != 4) begin n_fail++; $display("FAIL stream_latency: got %0d want 4", first); end
    n_checks++; if (last - first != 99) begin n_fail++; $display("FAIL stream_rate: got span %0d want 99", last - first); end
  endtask

  task automatic test_backpressure();
    logic [63:0]  rpat = 64'hB4D2_5A0F_C3E1_7896;
    logic [63:0]  vpat = 64'hF7DE_BB6F_DFF5_7BEE;
    logic [N+1:0] exp_q[$];
    logic [N+1:0] e;
    logic [N-1:0] held_s = '0;
    logic         held_co = 1'b0;
    bit           held = 1'b0;
    int           sent = 0;
    int           got = 0;
    for (int c = 0; c < 400 && got < 40; c++) begin
      @(negedge clk);
      bus.o_ready = rpat[c % 64];
      #1;
      n_checks++; if (bus.i_ready !== (~bus.o_valid | bus.o_ready)) begin n_fail++; $display("FAIL bp_i_ready: cycle %0d got %b want %b", c, bus.i_ready, ~bus.o_valid | bus.o_ready); end
      if (held) begin
        n_checks++;
        if (bus.o_valid !== 1'b1 || bus.o_s !== held_s || bus.o_co !== held_co) begin
          n_fail++; $display("FAIL bp_hold: cycle %0d got v=%b s=%h co=%b want v=1 s=%h co=%b", c, bus.o_valid, bus.o_s, bus.o_co, held_s, held_co);
        end
      end
      held = 1'b0;
      if (bus.o_valid === 1'b1) begin
        if (bus.o_ready) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL bp_extra: cycle %0d got s=%h want no beat", c, bus.o_s);
          end else begin
            e = exp_q.pop_front();
            if ({bus.o_co, bus.o_s} !== e[N:0]) begin n_fail++; $display("FAIL bp_sum: beat %0d got %h want %h", got, {bus.o_co, bus.o_s}, e[N:0]); end
          end
          got++;
        end else begin
          held    = 1'b1;
          held_s  = bus.o_s;
          held_co = bus.o_co;
        end
      end
      if (sent < 40 && vpat[c % 64]) begin
        send(vec_b(sent + 7), vec_a(sent + 11), sent[0], sent[1]);
        if (bus.i_ready) begin
          exp_q.push_back(model(vec_b(sent + 7), vec_a(sent + 11), sent[0], sent[1]));
          sent++;
        end
      end else begin
        bus.i_valid = 1'b0;
      end
    end
    n_checks++; if (got != 40) begin n_fail++; $display("FAIL bp_count: got %0d want 40", got); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_leftover: got %0d want 0", exp_q.size()); end
    bus.i_valid = 1'b0;
    bus.o_ready = 1'b1;
    for (int c = 0; c < 6; c++) @(negedge clk);
  endtask

  task automatic test_reset_midflight();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      send(vec_a(c + 50), vec_b(c + 50), 1'b0, 1'b0);
    end
    @(negedge clk);
    bus.i_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid: got %b want 0", bus.o_valid); end
    n_checks++; if (bus.i_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_i_ready: got %b want 1", bus.i_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ghost: cycle %0d got v=%b s=%h want v=0", c, bus.o_valid, bus.o_s); end
    end
    send(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
    @(negedge clk);
    bus.i_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (bus.o_valid !== 1'b1 || bus.o_s !== 32'h2345_678A) begin n_fail++; $display("FAIL mid_reset_fresh: got v=%b s=%h want v=1 s=2345678a", bus.o_valid, bus.o_s); end
    @(negedge clk);
  endtask

  task automatic test_degenerate();
    @(negedge clk);
    n_checks++; if (bus_deg.o_valid !== 1'b0) begin n_fail++; $display("FAIL deg_idle_valid: got %b want 0", bus_deg.o_valid); end
    bus_deg.i_valid = 1'b1;
    bus_deg.i_a = 32'h7FFF_FFFF; bus_deg.i_b = 32'h1; bus_deg.i_ci = 1'b0; bus_deg.i_sub = 1'b0;
    @(negedge clk);
    n_checks++; if (bus_deg.o_valid !== 1'b1) begin n_fail++; $display("FAIL deg_valid: got %b want 1", bus_deg.o_valid); end
    n_checks++; if (bus_deg.o_s !== 32'h8000_0000) begin n_fail++; $display("FAIL deg_s: got %h want 80000000", bus_deg.o_s); end
    n_checks++; if (bus_deg.o_co !== 1'b0) begin n_fail++; $display("FAIL deg_co: got %b want 0", bus_deg.o_co); end
`ifdef ADDER_CLA_PIPE_OVF_EN
    n_checks++; if (bus_deg.o_ovf !== 1'b1) begin n_fail++; $display("FAIL deg_ovf: got %b want 1", bus_deg.o_ovf); end
`endif
    bus_deg.i_a = 32'hFFFF_FFFF; bus_deg.i_b = 32'hFFFF_FFFF; bus_deg.i_ci = 1'b1;
    @(negedge clk);
    bus_deg.i_valid = 1'b0;
    n_checks++; if (bus_deg.o_s !== 32'hFFFF_FFFF || bus_deg.o_co !== 1'b1) begin n_fail++; $display("FAIL deg_b2b: got s=%h co=%b want s=ffffffff co=1", bus_deg.o_s, bus_deg.o_co); end
`ifdef ADDER_CLA_PIPE_OVF_EN
    n_checks++; if (bus_deg.o_ovf !== 1'b0) begin n_fail++; $display("FAIL deg_b2b_ovf: got %b want 0", bus_deg.o_ovf); end
`endif
    @(negedge clk);
    n_checks++; if (bus_deg.o_valid !== 1'b0) begin n_fail++; $display("FAIL deg_drain: got %b want 0", bus_deg.o_valid); end
  endtask

  initial begin
    bus.i_valid = 1'b0; bus.i_a = '0; bus.i_b = '0; bus.i_ci = 1'b0; bus.i_sub = 1'b0;
    bus_deg.i_valid = 1'b0; bus_deg.i_a = '0; bus_deg.i_b = '0;
    bus_deg.i_ci = 1'b0; bus_deg.i_sub = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_degenerate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
